serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 137 +++++++++++++
 tb/tb_serial_addsub.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor that processes SLICE bits per
// clock, LSB slice first, with the inter-slice carry held in a register.
// Results and flags are registered and only change on the edge that enters DONE.
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;        // already inverted for subtract
   logic [WIDTH-1:0] sum_q;      // partial result, filled slice by slice
   logic [WIDTH-1:0] sum_d;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] y_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             neg_q;

   int               slice_base;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] s_sl;
   logic             slice_cout;
   logic             msb_cin;    // carry into the top bit of this slice

   // Select the current slice and ripple the carry through it; the merged
   // sum_d is the full result once the last slice is folded in.
   always_comb begin
      logic cy;
      slice_base = int'(cnt_q) * SLICE;
      a_sl       = SLICE'(a_q >> slice_base);
      b_sl       = SLICE'(b_q >> slice_base);
      s_sl       = '0;
      msb_cin    = 1'b0;
      cy         = carry_q;
      for (int i = 0; i < SLICE; i++) begin
         if (i == SLICE - 1) begin
            msb_cin = cy;
         end
         s_sl[i] = a_sl[i] ^ b_sl[i] ^ cy;
         cy      = (a_sl[i] & b_sl[i]) | (cy & (a_sl[i] ^ b_sl[i]));
      end
      slice_cout = cy;
      sum_d      = sum_q;
      sum_d[slice_base +: SLICE] = s_sl;
   end

   // Control FSM plus all datapath and output registers; reset wins over
   // every transition and discards an in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= sub ? ~B : B;
                  carry_q <= sub ? 1'b1 : cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= slice_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  y_q     <= sum_d;
                  cout_q  <= slice_cout;
                  ovf_q   <= slice_cout ^ msb_cin;
                  zero_q  <= (sum_d == '0);
                  neg_q   <= sum_d[WIDTH-1];
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Y    = y_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;
   assign neg  = neg_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: four instances (8/2, 16/1, 16/4, 16/16) with
// per-instance scoreboards fed by the stimulus process and drained by monitors.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  start_v;
   logic        sub_i;
   logic        cin_i;
   logic [63:0] a_bus;
   logic [63:0] b_bus;
   logic [3:0]  busy_v, done_v, cout_v, ovf_v, zero_v, neg_v;
   logic [63:0] y_v [4];

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      longint unsigned y;
      logic            cout;
      logic            ovf;
      logic            zero;
      logic            neg;
      int              issue;
      longint unsigned a;
      longint unsigned b;
      logic            s;
      logic            c;
   } exp_t;

   exp_t            q [4][$];
   longint unsigned last_y [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int width_of(input int i);
      return (i == 0) ? 8 : 16;
   endfunction

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference model: plain integer arithmetic on the operands.
   function automatic exp_t model(input int i, input longint unsigned a_in, input longint unsigned b_in,
                                  input logic s, input logic c, input int issue);
      exp_t            e;
      int              w;
      longint unsigned m, a, b, full;
      longint          sa, sb, sv, one_c, smax, smin;
      w     = width_of(i);
      m     = (64'd1 << w) - 64'd1;
      a     = a_in & m;
      b     = b_in & m;
      sa    = ((a >> (w - 1)) != 0) ? longint'(a) - longint'(m) - 1 : longint'(a);
      sb    = ((b >> (w - 1)) != 0) ? longint'(b) - longint'(m) - 1 : longint'(b);
      one_c = c ? 1 : 0;
      smax  = longint'(m >> 1);
      smin  = -smax - 1;
      if (!s) begin
         full   = a + b + longint'(one_c);
         e.y    = full & m;
         e.cout = ((full >> w) & 64'd1) != 0;
         sv     = sa + sb + one_c;
      end else begin
         e.y    = (a - b) & m;
         e.cout = (a >= b);
         sv     = sa - sb;
      end
      e.ovf   = (sv > smax) || (sv < smin);
      e.zero  = (e.y == 0);
      e.neg   = ((e.y >> (w - 1)) & 64'd1) != 0;
      e.issue = issue;
      e.a     = a;
      e.b     = b;
      e.s     = s;
      e.c     = c;
      return e;
   endfunction

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         localparam int W = (gi == 0) ? 8 : 16;
         localparam int S = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 16;
         localparam int N = W / S;
         logic [W-1:0] y;
         int   busy_run = 0;
         logic prev_done = 1'b0;

         serial_addsub #(.WIDTH(W), .SLICE(S)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[gi]),
            .sub   (sub_i),
            .cin   (cin_i),
            .A     (a_bus[W-1:0]),
            .B     (b_bus[W-1:0]),
            .busy  (busy_v[gi]),
            .done  (done_v[gi]),
            .Y     (y),
            .cout  (cout_v[gi]),
            .ovf   (ovf_v[gi]),
            .zero  (zero_v[gi]),
            .neg   (neg_v[gi])
         );
         assign y_v[gi] = 64'(y);

         // Monitor: pops the scoreboard on every done pulse.
         always @(negedge clk) begin
            exp_t e;
            if (done_v[gi]) begin
               check($sformatf("done_pulse[%0d]", gi), 64'(prev_done), 64'd0);
               check($sformatf("busy_len[%0d]", gi), 64'(busy_run), 64'(N));
               if (q[gi].size() == 0) begin
                  fail_now($sformatf("unexpected_done[%0d]", gi));
               end else begin
                  e = q[gi].pop_front();
                  check($sformatf("y[%0d]", gi), y_v[gi], e.y);
                  check($sformatf("cout[%0d]", gi), 64'(cout_v[gi]), 64'(e.cout));
                  check($sformatf("ovf[%0d]", gi), 64'(ovf_v[gi]), 64'(e.ovf));
                  check($sformatf("zero[%0d]", gi), 64'(zero_v[gi]), 64'(e.zero));
                  check($sformatf("neg[%0d]", gi), 64'(neg_v[gi]), 64'(e.neg));
                  check($sformatf("latency[%0d]", gi), 64'(cyc - e.issue), 64'(N + 1));
                  last_y[gi] = e.y;
                  $display("inst%0d W=%0d S=%0d A=%0h B=%0h sub=%0b cin=%0b -> Y=%0h cout=%0b ovf=%0b zero=%0b neg=%0b lat=%0d",
                           gi, W, S, e.a, e.b, e.s, e.c, y_v[gi], cout_v[gi], ovf_v[gi],
                           zero_v[gi], neg_v[gi], cyc - e.issue);
               end
            end else if (busy_v[gi]) begin
               check($sformatf("hold_y[%0d]", gi), y_v[gi], last_y[gi]);
            end
            busy_run  = busy_v[gi] ? busy_run + 1 : 0;
            prev_done = done_v[gi];
         end
      end
   endgenerate

   function automatic longint unsigned rnd64();
      return {$urandom(), $urandom()};
   endfunction

   task automatic drive(input logic [3:0] mask, input longint unsigned a, input longint unsigned b,
                        input logic s, input logic c);
      a_bus   = a;
      b_bus   = b;
      sub_i   = s;
      cin_i   = c;
      start_v = mask;
      @(negedge clk);
      start_v = 4'b0000;
   endtask

   task automatic issue(input logic [3:0] mask, input longint unsigned a, input longint unsigned b,
                        input logic s, input logic c);
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) q[i].push_back(model(i, a, b, s, c, cyc));
      end
      drive(mask, a, b, s, c);
   endtask

   task automatic issue_lit(input longint unsigned a, input longint unsigned b, input logic s,
                            input logic c, input longint unsigned y, input logic co,
                            input logic ov, input logic z, input logic ng);
      exp_t e;
      e.y = y; e.cout = co; e.ovf = ov; e.zero = z; e.neg = ng;
      e.issue = cyc; e.a = a; e.b = b; e.s = s; e.c = c;
      q[0].push_back(e);
      drive(4'b0001, a, b, s, c);
   endtask

   // Waits for the masked scoreboards to drain, scrambling the operand
   // inputs meanwhile, then one more cycle so every instance is back in IDLE.
   task automatic wait_idle(input logic [3:0] mask, input int budget);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         a_bus = rnd64();
         b_bus = rnd64();
         sub_i = 1'($urandom());
         cin_i = 1'($urandom());
         #1;
         ok = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (mask[i] && q[i].size() != 0) ok = 1'b0;
         end
         if (ok) break;
      end
      if (!ok) fail_now("timeout waiting for done");
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_y[%0d]", tag, i), y_v[i], 64'd0);
         check($sformatf("%s_flags[%0d]", tag, i),
               64'({busy_v[i], done_v[i], cout_v[i], ovf_v[i], zero_v[i], neg_v[i]}), 64'd0);
      end
   endtask

   // start held high with fresh operands each cycle on the 8-bit instance;
   // it can only be accepted every N+2 cycles (N RUN, one DONE, one IDLE edge).
   task automatic held_start(input int iters);
      int              wait_cnt;
      longint unsigned a, b;
      logic            s, c;
      wait_cnt = 0;
      for (int k = 0; k < iters; k++) begin
         a = rnd64();
         b = rnd64();
         s = 1'($urandom());
         c = 1'($urandom());
         if (wait_cnt == 0) begin
            q[0].push_back(model(0, a, b, s, c, cyc));
            wait_cnt = 4 + 1;
         end else begin
            wait_cnt--;
         end
         a_bus = a; b_bus = b; sub_i = s; cin_i = c;
         start_v = 4'b0001;
         @(negedge clk);
      end
      start_v = 4'b0000;
      wait_idle(4'b0001, 40);
   endtask

   task automatic abort_test();
      a_bus = 64'h3C; b_bus = 64'h5A; sub_i = 1'b0; cin_i = 1'b0;
      start_v = 4'b0001;
      @(negedge clk);          // start edge done
      start_v = 4'b0000;
      @(negedge clk);          // first RUN edge done
      rst = 1'b1;              // sampled on the second RUN edge
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("abort");
      for (int i = 0; i < 4; i++) last_y[i] = 0;
      repeat (8) @(negedge clk);
      issue(4'b0001, 64'h3C, 64'h5A, 1'b0, 1'b1);
      wait_idle(4'b0001, 40);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) last_y[i] = 0;
      rst = 1'b1; start_v = 4'b0000; sub_i = 1'b0; cin_i = 1'b0;
      a_bus = 64'd0; b_bus = 64'd0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed 8-bit cases with hand-derived expectations
      issue_lit(64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, 1'b0, 1'b1);
      wait_idle(4'b0001, 40);
      issue_lit(64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_idle(4'b0001, 40);
      issue_lit(64'hFE, 64'h00, 1'b0, 1'b1, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_idle(4'b0001, 40);
      issue_lit(64'h05, 64'h07, 1'b1, 1'b0, 64'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_idle(4'b0001, 40);
      issue_lit(64'h80, 64'h01, 1'b1, 1'b0, 64'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_idle(4'b0001, 40);
      issue_lit(64'h05, 64'h07, 1'b1, 1'b1, 64'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_idle(4'b0001, 40);

      held_start(30);
      abort_test();

      // Random 8-bit operations
      repeat (25) begin
         issue(4'b0001, rnd64(), rnd64(), 1'($urandom()), 1'($urandom()));
         wait_idle(4'b0001, 40);
      end

      // 16-bit boundaries on all three slice widths
      issue(4'b1110, 64'hFFFF, 64'h0001, 1'b0, 1'b0); wait_idle(4'b1110, 60);
      issue(4'b1110, 64'h7FFF, 64'h0001, 1'b0, 1'b0); wait_idle(4'b1110, 60);
      issue(4'b1110, 64'h8000, 64'h0001, 1'b1, 1'b0); wait_idle(4'b1110, 60);
      issue(4'b1110, 64'h1234, 64'h1234, 1'b1, 1'b0); wait_idle(4'b1110, 60);
      issue(4'b1110, 64'hFFFF, 64'h0000, 1'b0, 1'b1); wait_idle(4'b1110, 60);

      // Random 16-bit sweep
      repeat (30) begin
         issue(4'b1110, rnd64(), rnd64(), 1'($urandom()), 1'($urandom()));
         wait_idle(4'b1110, 60);
      end

      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain[%0d]", i), 64'(q[i].size()), 64'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
